branch_pc_unit: RTL and testbench

- Program-counter and branch-resolution stage that consumes the ALU's 3-bit flag output ({carry, negative, zero}) and the register-file read value.
- Holds the PC, a latched flag register and a RUN/HALTED state machine.
- Each committed instruction either advances the PC sequentially or redirects it to a branch target.
- Generates the link write for branch-and-link and sits between the ALU and the instruction-fetch address path.

---
 rtl/kgp_branch_pkg.sv | 28 ++
 rtl/branch_cond.sv | 38 +++
 rtl/branch_pc_unit.sv | 104 ++++++++++
 tb/tb_branch_pc_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_branch_pkg.sv
// Shared encodings for the branch/PC stage: branch opcodes, flag bit
// positions and run-state values.
package kgp_branch_pkg;

   localparam logic [3:0] BR_NONE = 4'd0;
   localparam logic [3:0] BR_B    = 4'd1;
   localparam logic [3:0] BR_BR   = 4'd2;
   localparam logic [3:0] BR_BLTZ = 4'd3;
   localparam logic [3:0] BR_BZ   = 4'd4;
   localparam logic [3:0] BR_BNZ  = 4'd5;
   localparam logic [3:0] BR_BL   = 4'd6;
   localparam logic [3:0] BR_BCY  = 4'd7;
   localparam logic [3:0] BR_BNCY = 4'd8;
   localparam logic [3:0] BR_HALT = 4'd9;

   localparam int CARRY = 2;
   localparam int NEG   = 1;
   localparam int ZERO  = 0;

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   // Unconditional redirects; used to tell them apart from tested branches.
   function automatic logic is_uncond(input logic [3:0] op);
      return (op == BR_B) || (op == BR_BR) || (op == BR_BL);
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluation: decides whether the opcode is a
// redirecting branch and whether its condition holds.
module branch_cond
   import kgp_branch_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       br_op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [2:0]       flag_q,
   output logic             cond_taken,
   output logic             is_branch
);

   logic rs_zero;
   logic unused_flags;

   assign rs_zero      = (rs_val == '0);
   assign unused_flags = ^{flag_q[NEG], flag_q[ZERO]};

   always_comb begin
      cond_taken = 1'b0;
      is_branch  = 1'b1;
      if (is_uncond(br_op)) begin
         cond_taken = 1'b1;
      end else begin
         case (br_op)
            BR_BLTZ: cond_taken = rs_val[WIDTH-1];
            BR_BZ:   cond_taken = rs_zero;
            BR_BNZ:  cond_taken = !rs_zero;
            BR_BCY:  cond_taken = flag_q[CARRY];
            BR_BNCY: cond_taken = !flag_q[CARRY];
            default: is_branch  = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter, latched ALU flags and RUN/HALTED control; resolves each
// committed instruction into a sequential advance or a branch redirect.
module branch_pc_unit
   import kgp_branch_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] PC_RESET = '0,
   parameter int               PC_STEP  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [3:0]       br_op,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [2:0]       flag_in,
   input  logic             flag_we,
   input  logic             resume,
   output logic [WIDTH-1:0] pc,
   output logic [2:0]       flag_q,
   output logic             taken,
   output logic             link_we,
   output logic [WIDTH-1:0] link_data,
   output logic             halted
);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [2:0]       flags_q, flags_d;
   logic             taken_q, taken_d;
   logic [0:0]       state_q, state_d;

   logic             run;
   logic             commit;
   logic             cond_taken;
   logic             is_branch;
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] target_raw;
   logic [WIDTH-1:0] target;
   logic             unused_target;

   branch_cond #(.WIDTH(WIDTH)) u_cond (
      .br_op      (br_op),
      .rs_val     (rs_val),
      .flag_q     (flags_q),
      .cond_taken (cond_taken),
      .is_branch  (is_branch)
   );

   assign run           = (state_q == ST_RUN);
   assign commit        = en & run;
   assign seq_pc        = pc_q + WIDTH'(PC_STEP);
   assign target_raw    = (br_op == BR_BR) ? rs_val : (pc_q + imm);
   // Targets are word aligned regardless of the low offset bits supplied.
   assign target        = {target_raw[WIDTH-1:2], 2'b00};
   assign unused_target = ^target_raw[1:0];

   always_comb begin
      pc_d    = pc_q;
      flags_d = flags_q;
      taken_d = 1'b0;
      state_d = state_q;
      if (run) begin
         if (commit) begin
            if (flag_we) begin
               flags_d = flag_in;
            end
            if (br_op == BR_HALT) begin
               state_d = ST_HALTED;
            end else if (is_branch && cond_taken) begin
               pc_d    = target;
               taken_d = 1'b1;
            end else begin
               pc_d = seq_pc;
            end
         end
      end else if (resume) begin
         // Leaving HALTED steps past the HALT instruction.
         state_d = ST_RUN;
         pc_d    = seq_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= PC_RESET;
         flags_q <= 3'b000;
         taken_q <= 1'b0;
         state_q <= ST_RUN;
      end else begin
         pc_q    <= pc_d;
         flags_q <= flags_d;
         taken_q <= taken_d;
         state_q <= state_d;
      end
   end

   assign pc        = pc_q;
   assign flag_q    = flags_q;
   assign taken     = taken_q;
   assign halted    = (state_q == ST_HALTED);
   assign link_we   = commit && (br_op == BR_BL);
   assign link_data = seq_pc;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Randomised and directed bench for branch_pc_unit against a behavioural model.
module tb_branch_pc_unit;
   import kgp_branch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  br_op = 4'd0;
   logic [31:0] imm = 32'd0;
   logic [31:0] rs_val = 32'd0;
   logic [2:0]  flag_in = 3'd0;
   logic        flag_we = 1'b0;
   logic        resume = 1'b0;
   logic [31:0] pc;
   logic [2:0]  flag_q;
   logic        taken;
   logic        link_we;
   logic [31:0] link_data;
   logic        halted;

   branch_pc_unit #(.WIDTH(32), .PC_RESET(32'h0000_0000), .PC_STEP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .br_op     (br_op),
      .imm       (imm),
      .rs_val    (rs_val),
      .flag_in   (flag_in),
      .flag_we   (flag_we),
      .resume    (resume),
      .pc        (pc),
      .flag_q    (flag_q),
      .taken     (taken),
      .link_we   (link_we),
      .link_data (link_data),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   logic [31:0] m_pc;
   logic [2:0]  m_flag;
   logic        m_taken;
   logic        m_halted;

   int  tests = 0;
   int  fails = 0;
   bit  cmp_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Pins both the DUT and the model to a hand-computed value.
   task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl,
                      input logic [31:0] exp);
      chk({name, "_dut"}, act, exp);
      chk({name, "_model"}, mdl, exp);
   endtask

   task automatic model_reset();
      m_pc     = 32'h0;
      m_flag   = 3'b000;
      m_taken  = 1'b0;
      m_halted = 1'b0;
   endtask

   // One clock edge of the architectural rules, using the inputs being applied.
   task automatic model_edge();
      logic        tk;
      logic [31:0] tgt;
      m_taken = 1'b0;
      if (m_halted) begin
         if (resume) begin
            m_halted = 1'b0;
            m_pc     = m_pc + 32'd4;
         end
      end else if (en) begin
         tgt = m_pc + imm;
         case (br_op)
            4'd1: tk = 1'b1;
            4'd2: begin tk = 1'b1; tgt = rs_val; end
            4'd3: tk = rs_val[31];
            4'd4: tk = (rs_val == 32'd0);
            4'd5: tk = (rs_val != 32'd0);
            4'd6: tk = 1'b1;
            4'd7: tk = m_flag[2];
            4'd8: tk = !m_flag[2];
            default: tk = 1'b0;
         endcase
         if (br_op == 4'd9) m_halted = 1'b1;
         else if (tk) m_pc = tgt & 32'hFFFF_FFFC;
         else m_pc = m_pc + 32'd4;
         m_taken = tk;
         if (flag_we) m_flag = flag_in;
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("pc", pc, m_pc);
         chk("flag_q", {29'd0, flag_q}, {29'd0, m_flag});
         chk("taken", {31'd0, taken}, {31'd0, m_taken});
         chk("halted", {31'd0, halted}, {31'd0, m_halted});
         chk("link_we", {31'd0, link_we},
             {31'd0, (rst_n && !m_halted && en && br_op == 4'd6)});
         chk("link_data", link_data, m_pc + 32'd4);
      end
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] im, input logic [31:0] rs,
                        input logic fwe, input logic [2:0] fin, input logic e, input logic res);
      br_op   = op;
      imm     = im;
      rs_val  = rs;
      flag_we = fwe;
      flag_in = fin;
      en      = e;
      resume  = res;
   endtask

   task automatic clk_edge();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic step(input logic [3:0] op, input logic [31:0] im, input logic [31:0] rs,
                       input logic fwe, input logic [2:0] fin, input logic e, input logic res);
      drive(op, im, rs, fwe, fin, e, res);
      clk_edge();
   endtask

   task automatic do_reset();
      drive(BR_NONE, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0]  r_op;
      logic [31:0] r_imm;
      logic [31:0] r_rs;
      model_reset();
      cmp_on = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      lit("reset_pc", pc, m_pc, 32'h0);
      lit("reset_halted", {31'd0, halted}, {31'd0, m_halted}, 32'd0);

      step(BR_NONE, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      lit("seq1", pc, m_pc, 32'h4);
      step(BR_NONE, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      step(BR_NONE, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      lit("seq3", pc, m_pc, 32'hC);
      lit("seq_taken", {31'd0, taken}, {31'd0, m_taken}, 32'd0);
      step(BR_NONE, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      step(BR_B, 32'hFFFF_FFF0, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      lit("b_back", pc, m_pc, 32'h0);
      lit("b_taken", {31'd0, taken}, {31'd0, m_taken}, 32'd1);
      step(BR_BR, 32'd0, 32'h103, 1'b0, 3'd0, 1'b1, 1'b0);
      lit("br_align", pc, m_pc, 32'h100);

      step(BR_BR, 32'd0, 32'h3C, 1'b0, 3'd0, 1'b1, 1'b0);
      step(BR_NONE, 32'd0, 32'd0, 1'b1, 3'b100, 1'b1, 1'b0);
      lit("flag_latch", {29'd0, flag_q}, {29'd0, m_flag}, 32'd4);
      step(BR_BCY, 32'h20, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      lit("bcy_taken", pc, m_pc, 32'h60);
      step(BR_BCY, 32'h20, 32'd0, 1'b1, 3'b000, 1'b1, 1'b0);
      lit("bcy_oldcarry1", pc, m_pc, 32'h80);
      step(BR_BCY, 32'h20, 32'd0, 1'b1, 3'b100, 1'b1, 1'b0);
      lit("bcy_oldcarry0", pc, m_pc, 32'h84);
      lit("bcy_nt_taken", {31'd0, taken}, {31'd0, m_taken}, 32'd0);

      step(BR_BZ, 32'h8, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      lit("bz", pc, m_pc, 32'h8C);
      step(BR_BNZ, 32'h8, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      lit("bnz", pc, m_pc, 32'h90);
      step(BR_BLTZ, 32'h10, 32'h8000_0000, 1'b0, 3'd0, 1'b1, 1'b0);
      lit("bltz", pc, m_pc, 32'hA0);

      step(BR_BR, 32'd0, 32'h20, 1'b0, 3'd0, 1'b1, 1'b0);
      drive(BR_BL, 32'h100, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      #1;
      lit("bl_link_we", {31'd0, link_we}, {31'd0, !m_halted && en && br_op == 4'd6}, 32'd1);
      lit("bl_link_data", link_data, m_pc + 32'd4, 32'h24);
      clk_edge();
      lit("bl_pc", pc, m_pc, 32'h120);

      step(BR_BR, 32'd0, 32'h30, 1'b0, 3'd0, 1'b1, 1'b0);
      step(BR_HALT, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      lit("halt_flag", {31'd0, halted}, {31'd0, m_halted}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         step(BR_B, 32'h40, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      end
      lit("halt_hold", pc, m_pc, 32'h30);
      step(BR_NONE, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b1);
      lit("resume_pc", pc, m_pc, 32'h34);
      lit("resume_halted", {31'd0, halted}, {31'd0, m_halted}, 32'd0);
      step(BR_HALT, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      do_reset();
      lit("halt_reset_pc", pc, m_pc, 32'h0);
      lit("halt_reset_halted", {31'd0, halted}, {31'd0, m_halted}, 32'd0);
      step(BR_BR, 32'd0, 32'hFFFF_FFFC, 1'b0, 3'd0, 1'b1, 1'b0);
      step(BR_NONE, 32'd0, 32'd0, 1'b0, 3'd0, 1'b1, 1'b0);
      lit("wrap", pc, m_pc, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            r_op  = 4'($urandom_range(0, 15));
            r_imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed(12'($urandom)));
            case ($urandom_range(0, 3))
               0: r_rs = 32'd0;
               1: r_rs = 32'h8000_0000 | $urandom;
               default: r_rs = $urandom;
            endcase
            step(r_op, r_imm, r_rs, 1'($urandom), 3'($urandom),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0));
         end
      end

      drive(BR_NONE, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      cmp_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
